seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, number of consecutive identical samples (legal 2..255) needed to accept a digit.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port an  input  4  digit anodes, active-low; an[0] is the least significant digit.
REQ-005 SHALL have port seg  input  8  segments, active-low; seg[7]=dp, seg[6:0]=g..a.
REQ-006 SHALL have port value  output  16  last complete decoded frame; digit k occupies bits [4k+3:4k].
REQ-007 SHALL have port valid  output  1  one-cycle pulse when value updates.
REQ-008 SHALL have port err  output  1  registered with value: set if any digit in the frame was an illegal pattern.
REQ-009 SHALL have port digit_err  output  4  per-digit illegal-pattern flags for the frame in value.
REQ-010 SHALL have port dp  output  4  per-digit decimal-point state (active-high), see REQ-027.

Function
REQ-011 SHALL register an and seg once per cycle and compare each sample with the previous sample.
- "Select" = an has exactly one bit low; all-ones = blank; two or more low = collision.
REQ-012 SHALL run an 8-bit stability counter: clear on change, blank or collision; otherwise increment, saturating at 255.
REQ-013 SHALL accept a digit exactly once per dwell, in the cycle the counter first reaches STABLE_CYCLES-1 with a select present.
REQ-014 SHALL decode seg[6:0] as: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 18->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F (hex).
REQ-015 SHALL, for any other seg[6:0], store nibble 0 and set that digit's shadow error flag.
REQ-016 SHALL store the accepted nibble and error flag in a shadow slot indexed by the low anode, and set that slot's bit in a 4-bit captured mask.
REQ-017 SHALL overwrite the slot when a digit is re-accepted before frame completion; the mask bit stays set.
REQ-018 SHALL, in the cycle after the mask becomes 4'b1111, load value/digit_err/dp from the shadow, set err = OR of the errors, pulse valid, and clear the mask.
REQ-019 SHALL treat an acceptance that coincides with the frame load as belonging to the next frame (mask bit set after clear).
REQ-020 SHALL hold value, err, digit_err and dp constant between valid pulses.
REQ-021 SHALL hold valid low except during the single load cycle; never high two consecutive cycles.
REQ-022 SHALL take at least STABLE_CYCLES+2 cycles from first sample of a digit to the valid pulse of a frame that digit completes.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, clear value=16'h0000, valid=0, err=0, digit_err=4'h0, dp=4'h0, mask, shadow, counter and sample registers.
REQ-024 SHALL, if rst asserts mid-frame, discard the partial frame; no valid pulse until four fresh digits are accepted after rst deasserts.
REQ-025 SHALL treat the first post-reset sample as a change (counter starts at 0).

Configuration
REQ-026 SHALL compile decimal-point capture only when macro SEG_DP_CAPTURE_EN is defined.
REQ-027 SHALL, with SEG_DP_CAPTURE_EN, include seg[7] in the stability compare and capture dp[k] = ~seg[7] per digit.
- Without it: seg[7] is ignored everywhere and dp is tied to 4'h0.

Verification
REQ-028 SHALL cover: scan digits 0..3 with patterns A4, B0, 99, C0 (dp off), 6 cycles each -> one valid pulse; value=16'h0432, err=0.
REQ-029 SHALL cover: digit 1 driven with 8'hFF, others legal -> digit_err=4'b0010, err=1, value[7:4]=0.
REQ-030 SHALL cover: each digit held only 3 cycles with STABLE_CYCLES=4 -> no acceptance, valid never pulses.
REQ-031 SHALL cover: an=4'b1100 collision and an=4'b1111 blank interleaved with a legal scan -> both ignored; frame still completes with correct value.
REQ-032 SHALL cover: rst pulsed after 2 digits accepted -> outputs zero; next valid only after 4 new digits.
REQ-033 SHALL cover: with SEG_DP_CAPTURE_EN, digit 2 driven 8'h40 (decodes to 0, dp on) -> dp=4'b0100; without the macro -> dp=4'b0000.

Source files
------------

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder
// Purpose  : Rebuilds a 4-digit hex value from a multiplexed active-low
//            7-segment scan. Define SEG_DP_CAPTURE_EN to add decimal-point capture.
// Revision : 1.0 - initial release
// ============================================================================

module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [15:0] value,
    output logic        valid,
    output logic        err,
    output logic [3:0]  digit_err,
    output logic [3:0]  dp
);

    localparam logic [7:0] c_accept_cnt = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] c_cnt_max    = 8'hFF;

    logic [3:0]  an_q, an_prev_q;
    logic [7:0]  seg_q, seg_prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] shadow_val_q, shadow_val_d;
    logic [3:0]  shadow_err_q, shadow_err_d;
    logic [15:0] value_q, value_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [3:0]  digit_err_q, digit_err_d;

    logic [7:0]  w_seg_in;
    logic        w_select;
    logic [1:0]  w_idx;
    logic        w_same;
    logic        w_accept;
    logic        w_load;
    logic        w_bad;
    logic [3:0]  w_nibble;

`ifdef SEG_DP_CAPTURE_EN
    logic [3:0] shadow_dp_q, shadow_dp_d;
    logic [3:0] dp_q, dp_d;

    assign w_seg_in = seg;
`else
    // The decimal point plays no part in this build; keep it out of the compare.
    logic unused_seg_dp;
    assign unused_seg_dp = seg[7];
    assign w_seg_in      = {1'b0, seg[6:0]};
`endif

    always_comb begin
        w_select = 1'b1;
        w_idx    = 2'd0;
        case (an_q)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_select = 1'b0;
        endcase
    end

    always_comb begin
        w_bad    = 1'b0;
        w_nibble = 4'h0;
        case (seg_q[6:0])
            7'h40: w_nibble = 4'h0;
            7'h79: w_nibble = 4'h1;
            7'h24: w_nibble = 4'h2;
            7'h30: w_nibble = 4'h3;
            7'h19: w_nibble = 4'h4;
            7'h12: w_nibble = 4'h5;
            7'h02: w_nibble = 4'h6;
            7'h78: w_nibble = 4'h7;
            7'h00: w_nibble = 4'h8;
            7'h18: w_nibble = 4'h9;
            7'h08: w_nibble = 4'hA;
            7'h03: w_nibble = 4'hB;
            7'h46: w_nibble = 4'hC;
            7'h21: w_nibble = 4'hD;
            7'h06: w_nibble = 4'hE;
            7'h0E: w_nibble = 4'hF;
            default: w_bad = 1'b1;
        endcase
    end

    // Reaching STABLE_CYCLES-1 can only happen via an increment, so it fires once per dwell.
    always_comb begin
        w_same = (an_q == an_prev_q) && (seg_q == seg_prev_q);
        if (!w_select || !w_same) begin
            cnt_d = 8'h00;
        end else if (cnt_q == c_cnt_max) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        w_accept = w_select && (cnt_d == c_accept_cnt);
        w_load   = (mask_q == 4'hF);
    end

    always_comb begin
        mask_d       = w_load ? 4'h0 : mask_q;
        shadow_val_d = shadow_val_q;
        shadow_err_d = shadow_err_q;
        if (w_accept) begin
            mask_d[w_idx]                     = 1'b1;
            shadow_val_d[{w_idx, 2'b00} +: 4] = w_nibble;
            shadow_err_d[w_idx]               = w_bad;
        end
        valid_d     = w_load;
        value_d     = w_load ? shadow_val_q  : value_q;
        digit_err_d = w_load ? shadow_err_q  : digit_err_q;
        err_d       = w_load ? |shadow_err_q : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q         <= 4'h0;
            an_prev_q    <= 4'h0;
            seg_q        <= 8'h00;
            seg_prev_q   <= 8'h00;
            cnt_q        <= 8'h00;
            mask_q       <= 4'h0;
            shadow_val_q <= 16'h0000;
            shadow_err_q <= 4'h0;
            value_q      <= 16'h0000;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            digit_err_q  <= 4'h0;
        end else begin
            an_q         <= an;
            an_prev_q    <= an_q;
            seg_q        <= w_seg_in;
            seg_prev_q   <= seg_q;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            shadow_val_q <= shadow_val_d;
            shadow_err_q <= shadow_err_d;
            value_q      <= value_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            digit_err_q  <= digit_err_d;
        end
    end

`ifdef SEG_DP_CAPTURE_EN
    always_comb begin
        shadow_dp_d = shadow_dp_q;
        if (w_accept) begin
            shadow_dp_d[w_idx] = ~seg_q[7];
        end
        dp_d = w_load ? shadow_dp_q : dp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_dp_q <= 4'h0;
            dp_q        <= 4'h0;
        end else begin
            shadow_dp_q <= shadow_dp_d;
            dp_q        <= dp_d;
        end
    end

    assign dp = dp_q;
`else
    assign dp = 4'h0;
`endif

    assign value     = value_q;
    assign valid     = valid_q;
    assign err       = err_q;
    assign digit_err = digit_err_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_decoder
// Purpose  : Scoreboard bench for seg_scan_decoder driven by digit dwells.
// Revision : 1.0 - initial release
// ============================================================================

module tb_seg_scan_decoder;

    localparam int N = 4;

`ifdef SEG_DP_CAPTURE_EN
    localparam bit c_dp_en = 1'b1;
`else
    localparam bit c_dp_en = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  an  = 4'hF;
    logic [7:0]  seg = 8'hFF;
    logic [15:0] value;
    logic        valid;
    logic        err;
    logic [3:0]  digit_err;
    logic [3:0]  dp;

    seg_scan_decoder #(.STABLE_CYCLES(N)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .an        (an),
        .seg       (seg),
        .value     (value),
        .valid     (valid),
        .err       (err),
        .digit_err (digit_err),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic        err;
        logic [3:0]  digit_err;
        logic [3:0]  dp;
        int          start;
    } frame_t;

    frame_t     exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;

    // Reference model: one shadow slot per digit plus a captured mask.
    logic [15:0] m_nib  = '0;
    logic [3:0]  m_err  = '0;
    logic [3:0]  m_dp   = '0;
    logic [3:0]  m_mask = '0;
    logic [3:0]  prev_a = '0;
    logic [6:0]  prev_s = '0;

    logic [6:0] c_pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic bit decode(input logic [6:0] p, output logic [3:0] nib);
        nib = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (c_pat[i] == p) begin
                nib = 4'(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit sel_idx(input logic [3:0] a, output int idx);
        int zeros;
        zeros = 0;
        idx   = 0;
        for (int i = 0; i < 4; i++) begin
            if (!a[i]) begin
                zeros++;
                idx = i;
            end
        end
        return zeros == 1;
    endfunction

    // Present one pattern for 'hold' samples and update the model accordingly.
    task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int hold);
        int         idx;
        bit         is_sel;
        bit         legal;
        logic [3:0] nib;
        frame_t     f;
        an = a;
        seg = s;
        is_sel = sel_idx(a, idx);
        if (is_sel && hold >= N) begin
            legal = decode(s[6:0], nib);
            m_nib[idx*4 +: 4] = nib;
            m_err[idx]        = !legal;
            m_dp[idx]         = c_dp_en & ~s[7];
            m_mask[idx]       = 1'b1;
            if (m_mask == 4'hF) begin
                f.value     = m_nib;
                f.digit_err = m_err;
                f.err       = |m_err;
                f.dp        = m_dp;
                f.start     = cyc;
                exp_q.push_back(f);
                m_mask = 4'h0;
            end
        end
        prev_a = a;
        prev_s = s[6:0];
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        an  = 4'hF;
        seg = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        m_nib  = '0;
        m_err  = '0;
        m_dp   = '0;
        m_mask = '0;
        prev_a = '0;
        prev_s = '0;
    endtask

    task automatic drain();
        repeat (60) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic rand_dwell();
        logic [3:0] a;
        logic [7:0] s;
        int         r;
        int         i;
        int         j;
        do begin
            r = $urandom_range(0, 99);
            s = 8'($urandom);
            if (r < 75) begin
                a = ~(4'b0001 << $urandom_range(0, 3));
                if (r < 65) s = {1'($urandom_range(0, 1)), c_pat[$urandom_range(0, 15)]};
            end else if (r < 88) begin
                a = 4'hF;
            end else begin
                i = $urandom_range(0, 3);
                j = (i + 1 + $urandom_range(0, 2)) % 4;
                a = 4'hF;
                a[i] = 1'b0;
                a[j] = 1'b0;
                if ($urandom_range(0, 1) == 1) a[$urandom_range(0, 3)] = 1'b0;
            end
        end while (a == prev_a && s[6:0] == prev_s);
        dwell(a, s, $urandom_range(1, N + 3));
    endtask

    // Monitor: pops the scoreboard on each valid pulse and checks holding otherwise.
    initial begin
        frame_t      f;
        logic [15:0] held_val = '0;
        logic [8:0]  held_oth = '0;
        bit          prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_val   = '0;
                held_oth   = '0;
                prev_valid = 1'b0;
            end else if (valid) begin
                chk("valid_back_to_back", {15'b0, prev_valid}, 16'h0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid value=%0h required=no_pulse", value);
                end else begin
                    f = exp_q.pop_front();
                    chk("value", value, f.value);
                    chk("err", {15'b0, err}, {15'b0, f.err});
                    chk("digit_err", {12'b0, digit_err}, {12'b0, f.digit_err});
                    chk("dp", {12'b0, dp}, {12'b0, f.dp});
                    checks++;
                    if (cyc - f.start < N + 2) begin
                        errors++;
                        $display("FAIL latency actual=%0d required>=%0d", cyc - f.start, N + 2);
                    end
                end
                held_val   = value;
                held_oth   = {err, digit_err, dp};
                prev_valid = 1'b1;
            end else begin
                chk("hold_value", value, held_val);
                chk("hold_flags", {7'b0, err, digit_err, dp}, {7'b0, held_oth});
                prev_valid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_value", value, 16'h0000);
        chk("reset_valid", {15'b0, valid}, 16'h0);
        chk("reset_err", {15'b0, err}, 16'h0);
        chk("reset_digit_err", {12'b0, digit_err}, 16'h0);
        chk("reset_dp", {12'b0, dp}, 16'h0);
        @(posedge clk);
        #1;

        // Basic scan of 2,3,4,0 with dp off.
        dwell(4'b1110, 8'hA4, 6);
        dwell(4'b1101, 8'hB0, 6);
        dwell(4'b1011, 8'h99, 6);
        dwell(4'b0111, 8'hC0, 6);
        drain();
        chk("scan_value", value, 16'h0432);
        chk("scan_err", {15'b0, err}, 16'h0);
        @(posedge clk);
        #1;

        // Illegal pattern on digit 1.
        dwell(4'b1110, 8'hA4, 5);
        dwell(4'b1101, 8'hFF, 5);
        dwell(4'b1011, 8'h99, 5);
        dwell(4'b0111, 8'hC0, 5);
        drain();
        chk("illegal_digit_err", {12'b0, digit_err}, 16'h0002);
        chk("illegal_err", {15'b0, err}, 16'h1);
        chk("illegal_nibble", {12'b0, value[7:4]}, 16'h0);
        @(posedge clk);
        #1;

        // Dwells one sample too short are never accepted.
        dwell(4'b1110, 8'hF9, N - 1);
        dwell(4'b1101, 8'hA4, N - 1);
        dwell(4'b1011, 8'hB0, N - 1);
        dwell(4'b0111, 8'h99, N - 1);
        dwell(4'b1111, 8'hFF, 10);
        drain();
        chk("short_hold_value", value, 16'h0402);

        // Collisions and blanks interleaved with a legal scan.
        dwell(4'b1110, 8'h92, 6);
        dwell(4'b1111, 8'hFF, 2);
        dwell(4'b1100, 8'hF9, 6);
        dwell(4'b1101, 8'h82, 6);
        dwell(4'b1111, 8'h80, 5);
        dwell(4'b1011, 8'hF8, 7);
        dwell(4'b0000, 8'h80, 6);
        dwell(4'b0111, 8'h80, 8);
        drain();
        chk("collision_value", value, 16'h8765);
        @(posedge clk);
        #1;

        // Reset mid-frame discards the partial frame.
        dwell(4'b1110, 8'h98, 6);
        dwell(4'b1101, 8'h88, 6);
        do_reset();
        @(negedge clk);
        chk("midrst_value", value, 16'h0000);
        chk("midrst_err", {15'b0, err}, 16'h0);
        chk("midrst_digit_err", {12'b0, digit_err}, 16'h0);
        @(posedge clk);
        #1;
        dwell(4'b1011, 8'h83, 6);
        dwell(4'b0111, 8'hC6, 6);
        dwell(4'b1111, 8'hFF, 8);
        drain();
        chk("partial_after_rst", value, 16'h0000);
        dwell(4'b1110, 8'hA1, 6);
        dwell(4'b1101, 8'h86, 6);
        drain();
        chk("fresh_frame_value", value, 16'hCBED);
        @(posedge clk);
        #1;

        // Decimal point on digit 2 only.
        dwell(4'b1110, 8'hC0, 5);
        dwell(4'b1101, 8'hF9, 5);
        dwell(4'b1011, 8'h40, 5);
        dwell(4'b0111, 8'hA4, 5);
        drain();
        chk("dp_value", value, 16'h2010);
        chk("dp_flags", {12'b0, dp}, c_dp_en ? 16'h0004 : 16'h0000);
        @(posedge clk);
        #1;

        repeat (250) rand_dwell();
        dwell(4'b1111, 8'hFF, 6);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
